// File: rtl/fb_write_coalescer_if.sv
// fb_write_coalescer_if: pixel-in, flush, and DDR write-data/write-address FIFO signals
interface fb_write_coalescer_if #(parameter int LINE_ADDR_W = 27);
  logic                   pixel_valid_in;
  logic                   pixel_ready_out;
  logic [LINE_ADDR_W+2:0] pixel_addr_in;
  logic [15:0]            pixel_data_in;
  logic                   flush_in;
  logic                   flush_done_out;
  logic                   wdata_valid_out;
  logic                   wdata_ready_in;
  logic [143:0]           wdata_out;
  logic                   wlast_out;
  logic                   waddr_valid_out;
  logic                   waddr_ready_in;
  logic [LINE_ADDR_W-1:0] waddr_out;
  logic [31:0]            lines_written_out;
  modport master (
    input  pixel_valid_in, pixel_addr_in, pixel_data_in, flush_in, wdata_ready_in, waddr_ready_in,
    output pixel_ready_out, flush_done_out, wdata_valid_out, wdata_out, wlast_out,
           waddr_valid_out, waddr_out, lines_written_out
  );
  modport slave (
    output pixel_valid_in, pixel_addr_in, pixel_data_in, flush_in, wdata_ready_in, waddr_ready_in,
    input  pixel_ready_out, flush_done_out, wdata_valid_out, wdata_out, wlast_out,
           waddr_valid_out, waddr_out, lines_written_out
  );
endinterface

// File: rtl/fb_write_coalescer.sv
// fb_write_coalescer: merges RGB565 pixel writes into 128-bit strobed DDR line writes
module fb_write_coalescer #(
  parameter int LINE_ADDR_W  = 27,
  parameter int IDLE_TIMEOUT = 64
) (
  input logic clk_in,
  input logic rst_in,
  fb_write_coalescer_if.master bus
);
  localparam int TW = IDLE_TIMEOUT > 1 ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_M1 = IDLE_TIMEOUT > 0 ? TW'(IDLE_TIMEOUT - 1) : '0;
  logic                   acc_valid;
  logic [LINE_ADDR_W-1:0] acc_line;
  logic [127:0]           acc_data;
  logic [15:0]            acc_strb;
  logic                   dv, av;
  logic [143:0]           out_data;
  logic [LINE_ADDR_W-1:0] out_addr;
  logic [TW-1:0]          timer;
  logic                   flush_pend, flush_done;
  logic [31:0]            lines;
  logic                   out_free, accept, fp, timeout, close, fresh, done, dv_n, av_n, freed;
  logic [LINE_ADDR_W-1:0] pline;
  logic [2:0]             slot;
  logic [127:0]           new_data;
  logic [15:0]            new_strb;
  always_comb begin
    out_free = !dv && !av;
    accept   = bus.pixel_valid_in && bus.pixel_ready_out;
    pline    = bus.pixel_addr_in[LINE_ADDR_W+2:3];
    slot     = bus.pixel_addr_in[2:0];
    fp       = flush_pend || bus.flush_in;
    timeout  = IDLE_TIMEOUT != 0 && timer == TO_M1 && !accept;
    // a pixel for another line can only be accepted while out_free, so it always closes here
    close    = acc_valid && out_free &&
               ((&acc_strb) || timeout || (fp && !accept) || (accept && pline != acc_line));
    fresh    = close || !acc_valid;
    new_data = ((fresh ? 128'b0 : acc_data) & ~(128'hFFFF << {slot, 4'b0000})) |
               (128'(bus.pixel_data_in) << {slot, 4'b0000});
    new_strb = (fresh ? 16'b0 : acc_strb) | (16'h3 << {slot, 1'b0});
    dv_n     = dv && !bus.wdata_ready_in;
    av_n     = av && !bus.waddr_ready_in;
    freed    = (dv || av) && !dv_n && !av_n;
    done     = fp && !acc_valid && out_free && !accept;
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      acc_valid  <= 1'b0;
      acc_line   <= '0;
      acc_data   <= '0;
      acc_strb   <= '0;
      dv         <= 1'b0;
      av         <= 1'b0;
      out_data   <= '0;
      out_addr   <= '0;
      timer      <= '0;
      flush_pend <= 1'b0;
      flush_done <= 1'b0;
      lines      <= '0;
    end else begin
      dv <= close || dv_n;
      av <= close || av_n;
      if (close) begin
        out_data <= {acc_data, acc_strb};
        out_addr <= acc_line;
      end
      if (accept) begin
        acc_valid <= 1'b1;
        acc_line  <= pline;
        acc_data  <= new_data;
        acc_strb  <= new_strb;
      end else if (close) acc_valid <= 1'b0;
      timer      <= (accept || close || !acc_valid) ? '0 : (timer == TO_M1 ? timer : timer + 1'b1);
      flush_pend <= fp && !done;
      flush_done <= done;
      lines      <= lines + 32'(freed);
    end
  end
  assign bus.pixel_ready_out   = !rst_in && (!acc_valid || out_free);
  assign bus.flush_done_out    = flush_done;
  assign bus.wdata_valid_out   = dv;
  assign bus.wdata_out         = out_data;
  assign bus.wlast_out         = 1'b1;
  assign bus.waddr_valid_out   = av;
  assign bus.waddr_out         = out_addr;
  assign bus.lines_written_out = lines;
endmodule

// File: tb/tb_fb_write_coalescer.sv
// tb_fb_write_coalescer: directed checks of merging, closure triggers, stalls and reset
module tb_fb_write_coalescer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [143:0] dq[$];
  logic [26:0]  aq[$];
  always #5 clk = ~clk;
  fb_write_coalescer_if #(.LINE_ADDR_W(27)) b();
  fb_write_coalescer_if #(.LINE_ADDR_W(27)) b0();
  fb_write_coalescer #(.LINE_ADDR_W(27), .IDLE_TIMEOUT(64)) dut (.clk_in(clk), .rst_in(rst), .bus(b.master));
  fb_write_coalescer #(.LINE_ADDR_W(27), .IDLE_TIMEOUT(0)) dut0 (.clk_in(clk), .rst_in(rst), .bus(b0.master));
  always begin
    @(negedge clk);
    #4;
    if (b.wdata_valid_out && b.wdata_ready_in) dq.push_back(b.wdata_out);
    if (b.waddr_valid_out && b.waddr_ready_in) aq.push_back(b.waddr_out);
  end

  task automatic send_px(input logic [29:0] a, input logic [15:0] d);
    @(negedge clk);
    b.pixel_valid_in = 1'b1;
    b.pixel_addr_in  = a;
    b.pixel_data_in  = d;
    for (int i = 0; i < 200 && !b.pixel_ready_out; i++) @(negedge clk);
    tests++;
    if (b.pixel_ready_out !== 1'b1) begin
      fails++;
      $display("FAIL px_accept addr=%h ready=%b expected 1", a, b.pixel_ready_out);
    end
    @(negedge clk);
    b.pixel_valid_in = 1'b0;
  endtask

  task automatic do_flush(input string name);
    int i;
    @(negedge clk);
    b.flush_in = 1'b1;
    @(negedge clk);
    b.flush_in = 1'b0;
    for (i = 0; i < 200; i++) begin
      if (b.flush_done_out) break;
      @(negedge clk);
    end
    tests++;
    if (b.flush_done_out !== 1'b1) begin
      fails++;
      $display("FAIL %s flush_done=%b expected 1", name, b.flush_done_out);
    end
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({b.pixel_ready_out, b.wdata_valid_out, b.waddr_valid_out, b.flush_done_out} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_outputs got=%b expected 0000",
               {b.pixel_ready_out, b.wdata_valid_out, b.waddr_valid_out, b.flush_done_out});
    end
    repeat (3) @(negedge clk);
    tests++;
    if (b.lines_written_out !== 32'd0 || b.wlast_out !== 1'b1) begin
      fails++;
      $display("FAIL reset_count lines=%0d wlast=%b expected 0/1", b.lines_written_out, b.wlast_out);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (b.pixel_ready_out !== 1'b1) begin
      fails++;
      $display("FAIL reset_release ready=%b expected 1", b.pixel_ready_out);
    end
  endtask

  task automatic test_full_line();
    int d0 = dq.size();
    int a0 = aq.size();
    logic [31:0] l0 = b.lines_written_out;
    logic [143:0] w;
    for (int k = 0; k < 8; k++) send_px(30'h40 + 30'(k), 16'(16'h1111 * k));
    for (int i = 0; i < 20 && dq.size() == d0; i++) @(negedge clk);
    tests++;
    if (dq.size() != d0 + 1 || aq.size() != a0 + 1) begin
      fails++;
      $display("FAIL full_emit data_beats=%0d addr_beats=%0d expected 1/1", dq.size() - d0, aq.size() - a0);
    end else begin
      w = dq[d0];
      tests++;
      if (aq[a0] !== 27'h8 || w[15:0] !== 16'hFFFF) begin
        fails++;
        $display("FAIL full_hdr addr=%h strb=%h expected 8/ffff", aq[a0], w[15:0]);
      end
      for (int k = 0; k < 8; k++) begin
        tests++;
        if (w[16*k+16 +: 16] !== 16'(16'h1111 * k)) begin
          fails++;
          $display("FAIL full_slot%0d got=%h expected %h", k, w[16*k+16 +: 16], 16'(16'h1111 * k));
        end
      end
    end
    tests++;
    if (b.lines_written_out !== l0 + 1) begin
      fails++;
      $display("FAIL full_count got=%0d expected %0d", b.lines_written_out, l0 + 1);
    end
  endtask

  task automatic test_line_change();
    int d0 = dq.size();
    logic [143:0] w;
    send_px(30'h40, 16'h000A);
    send_px(30'h49, 16'h000B);
    tests++;
    if (b.wdata_valid_out !== 1'b1 || b.waddr_out !== 27'h8 || b.wdata_out !== 144'h000A_0003) begin
      fails++;
      $display("FAIL change_emit valid=%b addr=%h data=%h expected 1/8/a0003",
               b.wdata_valid_out, b.waddr_out, b.wdata_out);
    end
    do_flush("change_flush");
    tests++;
    if (dq.size() != d0 + 2) begin
      fails++;
      $display("FAIL change_beats got=%0d expected 2", dq.size() - d0);
    end else begin
      w = dq[d0 + 1];
      tests++;
      if (aq[aq.size() - 1] !== 27'h9 || w !== 144'h000B_0000_000C) begin
        fails++;
        $display("FAIL change_second addr=%h data=%h expected 9/b0000000c", aq[aq.size() - 1], w);
      end
    end
  endtask

  task automatic test_overwrite_flush();
    int d0 = dq.size();
    logic [143:0] w;
    send_px(30'h42, 16'hAAAA);
    send_px(30'h42, 16'h5555);
    do_flush("ovw_flush");
    tests++;
    if (dq.size() != d0 + 1) begin
      fails++;
      $display("FAIL ovw_beats got=%0d expected 1 before flush_done", dq.size() - d0);
    end else begin
      w = dq[d0];
      tests++;
      if (w[15:0] !== 16'h0030 || w[63:48] !== 16'h5555 || aq[aq.size() - 1] !== 27'h8) begin
        fails++;
        $display("FAIL ovw_line strb=%h slot2=%h addr=%h expected 0030/5555/8",
                 w[15:0], w[63:48], aq[aq.size() - 1]);
      end
    end
  endtask

  task automatic test_stall();
    int d0, a0, bad_ready, bad_data;
    logic [31:0] l0;
    b.wdata_ready_in = 1'b0;
    send_px(30'h80, 16'h1234);
    send_px(30'h88, 16'h5678);
    d0 = dq.size();
    a0 = aq.size();
    l0 = b.lines_written_out;
    b.pixel_valid_in = 1'b1;
    b.pixel_addr_in  = 30'h90;
    b.pixel_data_in  = 16'h9ABC;
    bad_ready = 0;
    bad_data  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b.pixel_ready_out !== 1'b0) bad_ready++;
      if (b.wdata_valid_out !== 1'b1 || b.wdata_out !== 144'h1234_0003) bad_data++;
    end
    tests++;
    if (bad_ready != 0 || bad_data != 0) begin
      fails++;
      $display("FAIL stall_hold ready_high=%0d data_changed=%0d expected 0/0", bad_ready, bad_data);
    end
    tests++;
    if (aq.size() != a0 + 1 || dq.size() != d0 || b.waddr_valid_out !== 1'b0 || b.lines_written_out !== l0) begin
      fails++;
      $display("FAIL stall_chan addr_beats=%0d data_beats=%0d avalid=%b lines=%0d expected 1/0/0/%0d",
               aq.size() - a0, dq.size() - d0, b.waddr_valid_out, b.lines_written_out, l0);
    end
    b.wdata_ready_in = 1'b1;
    @(negedge clk);
    tests++;
    if (b.lines_written_out !== l0 + 1 || b.pixel_ready_out !== 1'b1) begin
      fails++;
      $display("FAIL stall_release lines=%0d ready=%b expected %0d/1", b.lines_written_out, b.pixel_ready_out, l0 + 1);
    end
    @(negedge clk);
    b.pixel_valid_in = 1'b0;
    do_flush("stall_flush");
    tests++;
    if (dq.size() != d0 + 3 || aq[aq.size() - 1] !== 27'h12 || dq[dq.size() - 1] !== 144'h9ABC_0003) begin
      fails++;
      $display("FAIL stall_drain beats=%0d last_addr=%h expected 3/12", dq.size() - d0, aq[aq.size() - 1]);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    send_px(30'h100, 16'hBEEF);
    while (!b.wdata_valid_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n != 64 || b.waddr_out !== 27'h20 || b.wdata_out !== 144'hBEEF_0003) begin
      fails++;
      $display("FAIL timeout_emit cycles=%0d addr=%h data=%h expected 64/20/beef0003", n, b.waddr_out, b.wdata_out);
    end
    @(negedge clk);
  endtask

  task automatic test_no_timeout();
    int seen = 0;
    int i;
    logic [143:0] w = '0;
    @(negedge clk);
    b0.pixel_valid_in = 1'b1;
    b0.pixel_addr_in  = 30'h40;
    b0.pixel_data_in  = 16'h7777;
    @(negedge clk);
    b0.pixel_valid_in = 1'b0;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b0.wdata_valid_out) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL no_timeout valid_cycles=%0d expected 0", seen);
    end
    b0.flush_in = 1'b1;
    @(negedge clk);
    b0.flush_in = 1'b0;
    for (i = 0; i < 50 && !b0.flush_done_out; i++) begin
      if (b0.wdata_valid_out) w = b0.wdata_out;
      @(negedge clk);
    end
    tests++;
    if (b0.flush_done_out !== 1'b1 || w !== 144'h7777_0003) begin
      fails++;
      $display("FAIL no_timeout_flush done=%b data=%h expected 1/77770003", b0.flush_done_out, w);
    end
  endtask

  task automatic test_reset_mid_stall();
    int d0, a0, seen;
    b.wdata_ready_in = 1'b0;
    b.waddr_ready_in = 1'b0;
    send_px(30'h200, 16'h0101);
    send_px(30'h208, 16'h0202);
    tests++;
    if (b.wdata_valid_out !== 1'b1 || b.waddr_valid_out !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre valids=%b%b expected 11", b.wdata_valid_out, b.waddr_valid_out);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({b.wdata_valid_out, b.waddr_valid_out, b.pixel_ready_out} !== 3'b000 || b.lines_written_out !== 32'd0) begin
      fails++;
      $display("FAIL rst_async valids/ready=%b lines=%0d expected 000/0",
               {b.wdata_valid_out, b.waddr_valid_out, b.pixel_ready_out}, b.lines_written_out);
    end
    @(negedge clk);
    rst = 1'b0;
    b.wdata_ready_in = 1'b1;
    b.waddr_ready_in = 1'b1;
    d0 = dq.size();
    a0 = aq.size();
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (b.wdata_valid_out || b.waddr_valid_out) seen++;
    end
    tests++;
    if (seen != 0 || dq.size() != d0 || aq.size() != a0 || b.lines_written_out !== 32'd0) begin
      fails++;
      $display("FAIL rst_after valid_cycles=%0d beats=%0d lines=%0d expected 0/0/0",
               seen, dq.size() - d0, b.lines_written_out);
    end
  endtask

  initial begin
    b.pixel_valid_in = 1'b0;
    b.pixel_addr_in  = '0;
    b.pixel_data_in  = '0;
    b.flush_in       = 1'b0;
    b.wdata_ready_in = 1'b1;
    b.waddr_ready_in = 1'b1;
    b0.pixel_valid_in = 1'b0;
    b0.pixel_addr_in  = '0;
    b0.pixel_data_in  = '0;
    b0.flush_in       = 1'b0;
    b0.wdata_ready_in = 1'b1;
    b0.waddr_ready_in = 1'b1;
    test_reset();
    test_full_line();
    test_line_change();
    test_overwrite_flush();
    test_stall();
    test_timeout();
    test_no_timeout();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
